// File: rtl/mock_keypad_stimulus_pkg.sv
// Shared types and constants for the mock keypad stimulus source.
//   mode_e      : key value source (COUNT, SCRIPT, RANDOM, reserved)
//   key_state_e : key_down hold FSM states
//   LFSR_TAPS   : Galois feedback mask for the 8-bit random source
//   lfsr_step   : one Galois LFSR shift
package mock_keypad_stimulus_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'b00,
    MODE_SCRIPT = 2'b01,
    MODE_RANDOM = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } key_state_e;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Right-shifting Galois form: the bit shifted out decides whether the
  // feedback mask is applied.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/mock_keypad_stimulus_if.sv
// Keypad digit/valid bus, shared by the real decoder and the mock source.
//   enable   : tick counter run control (consumer -> source)
//   mode     : value source select (consumer -> source)
//   digit    : current key value, held between events
//   valid    : one-cycle pulse per key event
//   key_down : key held level, starts with valid
//   done     : sticky end-of-script flag
interface mock_keypad_stimulus_if #(
  parameter int DIGIT_W = 4
);
  import mock_keypad_stimulus_pkg::*;

  logic               enable;
  mode_e              mode;
  logic [DIGIT_W-1:0] digit;
  logic               valid;
  logic               key_down;
  logic               done;

  modport master (
    input  enable,
    input  mode,
    output digit,
    output valid,
    output key_down,
    output done
  );

  modport slave (
    output enable,
    output mode,
    input  digit,
    input  valid,
    input  key_down,
    input  done
  );

endinterface

// File: rtl/mock_keypad_stimulus_tick_divider.sv
// Free-running interval timer producing a one-cycle tick every TICK_DIV
// enabled cycles.
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   enable : 1 = counter advances, 0 = counter frozen
//   tick   : high for the cycle in which the count sits at TICK_DIV-1
module tick_divider #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int              CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  // The wrap out of LAST ignores enable: once the tick cycle is reached it
  // is consumed exactly once, even if enable drops in that same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mock_keypad_stimulus.sv
// Synthetic keypad source: emits key events on the decoder's digit/valid
// bus so code-entry logic can run without physical keys.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   kp    : keypad bus (master side) - enable/mode in; digit, valid,
//           key_down, done out
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | key released, waiting for the next tick
// ST_HOLD | key_down high, hold down-counter running
module mock_keypad_stimulus
  import mock_keypad_stimulus_pkg::*;
#(
  parameter int                          TICK_DIV    = 1000,
  parameter int                          DIGIT_W     = 4,
  parameter int                          MODULUS     = 16,
  parameter int                          HOLD_CYCLES = 3,
  parameter int                          SCRIPT_LEN  = 4,
  parameter logic [SCRIPT_LEN*DIGIT_W-1:0] SCRIPT    = 16'h4321,
  parameter bit                          LOOP        = 1'b1,
  parameter logic [7:0]                  LFSR_SEED   = 8'hA5
) (
  input logic                  clk,
  input logic                  reset,
  mock_keypad_stimulus_if.master kp
);

  // Index must cover both the count range and the script range.
  localparam int               IDX_W    = (DIGIT_W > 4) ? DIGIT_W : 4;
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(MODULUS - 1);
  localparam logic [IDX_W-1:0] SCR_LAST = IDX_W'(SCRIPT_LEN - 1);
  localparam int               HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  key_state_e         r_state;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [DIGIT_W-1:0] r_digit;
  logic               r_valid;
  logic               r_done;
  logic [IDX_W-1:0]   r_index;
  logic [7:0]         r_lfsr;
  mode_e              r_last_mode;

  logic               w_tick;
  mode_e              w_mode_n;
  logic               w_mode_chg;
  logic [IDX_W-1:0]   w_idx_eff;
  logic               w_done_eff;
  logic               w_event;
  logic [7:0]         w_lfsr_step;
  logic [DIGIT_W-1:0] w_script_digit;

  key_state_e         w_state_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [DIGIT_W-1:0] w_digit_nxt;
  logic               w_done_nxt;
  logic [IDX_W-1:0]   w_index_nxt;
  logic [7:0]         w_lfsr_nxt;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .enable (kp.enable),
    .tick   (w_tick)
  );

  // Reserved mode behaves as COUNT, and is tracked as COUNT so that
  // toggling between the two does not restart the sequence.
  assign w_mode_n   = (kp.mode == MODE_RSVD) ? MODE_COUNT : kp.mode;
  assign w_mode_chg = (w_mode_n != r_last_mode);

  // A mode change restarts the index and clears done before the value is
  // chosen, so the first event in the new mode is always entry 0.
  assign w_idx_eff   = w_mode_chg ? '0 : r_index;
  assign w_done_eff  = w_mode_chg ? 1'b0 : r_done;
  assign w_event     = w_tick && !w_done_eff;
  assign w_lfsr_step = lfsr_step(r_lfsr);

  always_comb begin
    w_script_digit = '0;
    for (int i = 0; i < SCRIPT_LEN; i++) begin
      if (w_idx_eff == IDX_W'(i)) begin
        w_script_digit = SCRIPT[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // Value selection
  always_comb begin
    w_digit_nxt = r_digit;
    w_lfsr_nxt  = r_lfsr;
    w_index_nxt = w_tick ? w_idx_eff : r_index;
    w_done_nxt  = w_tick ? w_done_eff : r_done;
    if (w_event) begin
      case (w_mode_n)
        MODE_SCRIPT: begin
          w_digit_nxt = w_script_digit;
          if (w_idx_eff == SCR_LAST) begin
            w_index_nxt = '0;
            if (!LOOP) begin
              w_done_nxt = 1'b1;
            end
          end else begin
            w_index_nxt = w_idx_eff + IDX_W'(1);
          end
        end
        MODE_RANDOM: begin
          w_lfsr_nxt  = w_lfsr_step;
          w_digit_nxt = DIGIT_W'(w_lfsr_step);
        end
        default: begin
          w_digit_nxt = DIGIT_W'(w_idx_eff);
          w_index_nxt = (w_idx_eff == CNT_LAST) ? '0 : (w_idx_eff + IDX_W'(1));
        end
      endcase
    end
  end

  // Hold FSM next state
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    if (w_event) begin
      w_state_nxt = ST_HOLD;
      w_hold_nxt  = HOLD_LAST;
    end else if (r_state == ST_HOLD) begin
      if (r_hold_cnt == '0) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_hold_nxt = r_hold_cnt - HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digit     <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_index     <= '0;
      r_lfsr      <= LFSR_SEED;
      r_last_mode <= MODE_COUNT;
    end else begin
      r_digit <= w_digit_nxt;
      r_valid <= w_event;
      r_done  <= w_done_nxt;
      r_index <= w_index_nxt;
      r_lfsr  <= w_lfsr_nxt;
      if (w_tick) begin
        r_last_mode <= w_mode_n;
      end
    end
  end

  assign kp.digit    = r_digit;
  assign kp.valid    = r_valid;
  assign kp.key_down = (r_state == ST_HOLD);
  assign kp.done     = r_done;

endmodule
